dwc_fault_manager: RTL
======================

Name: dwc_fault_manager

Overview:
- Sequential controller placed after a bank of N duplication-with-comparison (DwC) detection units.
- Samples their per-unit mismatch flags on a data-valid strobe and tells transient faults apart from persistent ones by requesting bounded re-execution of the duplicated datapath.
- Escalates to a sticky alarm after MAX_RETRY consecutive failing comparisons.
- Drives the stall/retry signals for the datapath and exposes fault status for the host.

Parameters:
- N, 4, number of DwC error inputs (1..32).
- ERR_POL, 1, mismatch polarity of port_error_in: 1 = high means mismatch, 0 = low means mismatch.
- MAX_RETRY, 3, consecutive failing compares before ALARM (1..15).
- RETRY_WAIT, 2, hold cycles between a retry request and the next accepted compare (1..255).
- CNT_W, 8, width of the saturating event counters.

Ports:
- port_clk  input  1  clock; all state updates on the rising edge.
- port_rst  input  1  synchronous, active-high reset.
- port_error_in  input  N  raw DwC comparator outputs, polarity per ERR_POL.
- port_valid  input  1  the current cycle's comparator outputs are meaningful.
- port_clear  input  1  host acknowledge; exits ALARM and clears the sticky vector.
- port_hold  output  1  stall request to the upstream datapath.
- port_retry  output  1  one-cycle pulse: re-issue the last operation.
- port_alarm  output  1  persistent fault detected (sticky).
- port_fault_vec  output  N  OR-accumulated mismatch map since the last clear/reset.
- port_transient_cnt  output  CNT_W  saturating count of faults recovered by retry.
- port_persist_cnt  output  CNT_W  saturating count of ALARM entries.
- port_state  output  2  encoded FSM state.

Behaviour:
- Mismatch is computed combinationally: mis = (ERR_POL ? port_error_in : ~port_error_in); any_mis = |mis & port_valid.
- Reset: state=MONITOR (2'd0); hold=0, retry=0, alarm=0, fault_vec=0, both counters=0, retry count rc=0, wait timer=0.
- States are MONITOR=0, WAIT=1, CHECK=2, ALARM=3.
- MONITOR:
  - any_mis → next cycle: state=WAIT, retry=1 for exactly that cycle, hold=1, rc=1, timer=RETRY_WAIT, fault_vec |= mis.
  - No mismatch → stay; port_valid=0 is ignored.
- WAIT:
  - hold=1; timer decrements each cycle.
  - At timer==1 → CHECK next cycle.
  - Inputs are ignored in this state.
- CHECK:
  - hold=0; waits for port_valid.
  - Valid and clean → MONITOR, transient_cnt+1 (saturating), rc=0.
  - Valid and any_mis with rc<MAX_RETRY → WAIT, retry pulse, rc+1, fault_vec |= mis.
  - Valid and any_mis with rc==MAX_RETRY → ALARM, alarm=1, hold=1, persist_cnt+1 (saturating), fault_vec |= mis.
- ALARM:
  - alarm=1 and hold=1 held; mismatches keep OR-ing into fault_vec.
  - port_clear → MONITOR next cycle, alarm=0, hold=0, fault_vec=0, rc=0; counters keep their values.
- port_clear outside ALARM clears fault_vec only. If it coincides with a new mismatch, the new mis bits win (fault_vec = mis).
- MAX_RETRY=1: the first failing CHECK goes to ALARM.
- Counters stop at 2^CNT_W-1 and do not wrap.
- Reset asserted in any state, including mid-WAIT, forces the reset values on the next edge. No retry pulse is produced.
- Outputs are registered; latency from the failing valid compare to retry/hold is 1 cycle.

Decomposition:
- Shared package dwc_pkg:
  - state enum (MONITOR, WAIT, CHECK, ALARM) and its 2-bit encoding;
  - default constants for MAX_RETRY, RETRY_WAIT and CNT_W.
- One natural sub-module: dwc_sat_counter (CNT_W-wide, synchronous clear, increment enable, saturation), instantiated twice.

Test Plan:
- Reset, then N=4, valid=1, error_in=4'b0000 for 10 cycles → state stays 0; all outputs 0; counters 0.
- One-cycle error_in=4'b0100 with valid, then clean compares →
  - retry pulses 1 cycle after the strobe;
  - hold high 2 cycles, then CHECK;
  - next clean valid → MONITOR, transient_cnt=1, fault_vec=4'b0100.
- error_in=4'b0001 on every valid →
  - 3 retry pulses;
  - third failing CHECK → alarm=1, persist_cnt=1, hold stays 1;
  - port_clear → alarm=0, fault_vec=0, state=0.
- ERR_POL=0, error_in=4'b1111 → no action; error_in=4'b1110 → retry pulse, fault_vec=4'b0001.
- Reset asserted in WAIT (timer=1) → next cycle all outputs at reset values, no retry pulse, no CHECK entry.
- CNT_W=2, 5 recovered transients → transient_cnt saturates at 3.

Source files
------------

// File: rtl/dwc_pkg.sv
// Shared types and defaults for the DwC fault manager and its helpers.
package dwc_pkg;

  // Controller states; the encoding is visible to the host on port_state.
  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CHECK   = 2'd2,
    ST_ALARM   = 2'd3
  } dwc_state_e;

  localparam int DWC_MAX_RETRY  = 3;
  localparam int DWC_RETRY_WAIT = 2;
  localparam int DWC_CNT_W      = 8;

endpackage

// File: rtl/dwc_sat_counter.sv
// Saturating event counter: synchronous clear, increment enable, sticks at all-ones.
module dwc_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // Count enabled events, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dwc_fault_manager.sv
// Fault manager for a bank of DwC comparators: retries on mismatch to filter
// transients, raises a sticky alarm when mismatches persist across retries.
module dwc_fault_manager
  import dwc_pkg::*;
#(
  parameter int N          = 4,
  parameter int ERR_POL    = 1,
  parameter int MAX_RETRY  = DWC_MAX_RETRY,
  parameter int RETRY_WAIT = DWC_RETRY_WAIT,
  parameter int CNT_W      = DWC_CNT_W
) (
  input  logic             port_clk,
  input  logic             port_rst,
  input  logic [N-1:0]     port_error_in,
  input  logic             port_valid,
  input  logic             port_clear,
  output logic             port_hold,
  output logic             port_retry,
  output logic             port_alarm,
  output logic [N-1:0]     port_fault_vec,
  output logic [CNT_W-1:0] port_transient_cnt,
  output logic [CNT_W-1:0] port_persist_cnt,
  output logic [1:0]       port_state
);

  localparam logic [3:0] MAX_RC  = 4'(MAX_RETRY);
  localparam logic [7:0] WAIT_LD = 8'(RETRY_WAIT);

  dwc_state_e   state_reg, state_next;
  logic [3:0]   rc_reg, rc_next;
  logic [7:0]   timer_reg, timer_next;
  logic         hold_reg, hold_next;
  logic         retry_reg, retry_next;
  logic         alarm_reg, alarm_next;
  logic [N-1:0] fv_reg, fv_next;
  logic         tc_inc, pc_inc;

  logic [N-1:0] mis, mis_v;
  logic         any_mis;

  // Normalise comparator polarity; only valid cycles carry meaningful flags.
  assign mis     = (ERR_POL != 0) ? port_error_in : ~port_error_in;
  assign mis_v   = port_valid ? mis : '0;
  assign any_mis = |mis_v;

  // Next-state and registered-output decode.
  always_comb begin
    state_next = state_reg;
    rc_next    = rc_reg;
    timer_next = timer_reg;
    hold_next  = hold_reg;
    retry_next = 1'b0;
    alarm_next = alarm_reg;
    fv_next    = fv_reg;
    tc_inc     = 1'b0;
    pc_inc     = 1'b0;

    // Outside ALARM a host clear wipes the map; fresh mismatch bits OR in after.
    if (port_clear && (state_reg != ST_ALARM)) fv_next = '0;

    case (state_reg)
      ST_MONITOR: begin
        hold_next  = 1'b0;
        alarm_next = 1'b0;
        if (any_mis) begin
          state_next = ST_WAIT;
          retry_next = 1'b1;
          hold_next  = 1'b1;
          rc_next    = 4'd1;
          timer_next = WAIT_LD;
          fv_next    = fv_next | mis_v;
        end
      end
      ST_WAIT: begin
        // Comparator flags are stale while the datapath re-executes.
        hold_next  = 1'b1;
        timer_next = timer_reg - 8'd1;
        if (timer_reg <= 8'd1) begin
          state_next = ST_CHECK;
          hold_next  = 1'b0;
          timer_next = 8'd0;
        end
      end
      ST_CHECK: begin
        hold_next = 1'b0;
        if (port_valid) begin
          if (!any_mis) begin
            state_next = ST_MONITOR;
            tc_inc     = 1'b1;
            rc_next    = 4'd0;
          end else if (rc_reg < MAX_RC) begin
            state_next = ST_WAIT;
            retry_next = 1'b1;
            hold_next  = 1'b1;
            rc_next    = rc_reg + 4'd1;
            timer_next = WAIT_LD;
            fv_next    = fv_next | mis_v;
          end else begin
            state_next = ST_ALARM;
            alarm_next = 1'b1;
            hold_next  = 1'b1;
            pc_inc     = 1'b1;
            fv_next    = fv_next | mis_v;
          end
        end
      end
      ST_ALARM: begin
        hold_next  = 1'b1;
        alarm_next = 1'b1;
        fv_next    = fv_reg | mis_v;
        if (port_clear) begin
          state_next = ST_MONITOR;
          hold_next  = 1'b0;
          alarm_next = 1'b0;
          fv_next    = '0;
          rc_next    = 4'd0;
        end
      end
      default: state_next = ST_MONITOR;
    endcase
  end

  // State and output registers.
  always_ff @(posedge port_clk) begin
    if (port_rst) begin
      state_reg <= ST_MONITOR;
      rc_reg    <= 4'd0;
      timer_reg <= 8'd0;
      hold_reg  <= 1'b0;
      retry_reg <= 1'b0;
      alarm_reg <= 1'b0;
      fv_reg    <= '0;
    end else begin
      state_reg <= state_next;
      rc_reg    <= rc_next;
      timer_reg <= timer_next;
      hold_reg  <= hold_next;
      retry_reg <= retry_next;
      alarm_reg <= alarm_next;
      fv_reg    <= fv_next;
    end
  end

  dwc_sat_counter #(.CNT_W(CNT_W)) u_transient_cnt (
    .clk   (port_clk),
    .srst  (port_rst),
    .inc   (tc_inc),
    .count (port_transient_cnt)
  );

  dwc_sat_counter #(.CNT_W(CNT_W)) u_persist_cnt (
    .clk   (port_clk),
    .srst  (port_rst),
    .inc   (pc_inc),
    .count (port_persist_cnt)
  );

  assign port_hold      = hold_reg;
  assign port_retry     = retry_reg;
  assign port_alarm     = alarm_reg;
  assign port_fault_vec = fv_reg;
  assign port_state     = state_reg;

endmodule
